// File: rtl/ovl_step_delta.sv
// ovl_step_delta
//   Step-delta assertion checker. It watches a WIDTH-bit expression and
//   requires every change between sampled clock edges to be exactly +/-VALUE.
//   MODE selects the legal direction:
//     0 = decrement only
//     1 = increment only
//     2 = either direction
//   Also provided:
//     - an optional ban on modular wrap-around (ALLOW_WRAP=0)
//     - a stall timeout (MAX_HOLD)
//     - a registered fire vector
//     - a saturating count of firing cycles
//
// Ports:
//   clock      in   sampling clock, rising edge
//   reset      in   asynchronous active-high reset
//   enable     in   check enable, sampled on clock
//   test_expr  in   [WIDTH-1:0] monitored expression
//   fire       out  [2:0] {X/Z detected, hold timeout, step violation}, one-cycle pulses
//   fire_count out  [CNT_WIDTH-1:0] saturating count of cycles with any fire bit set
//   armed      out  a reference sample is held
//
// Optional feature macro: IVL_UVM_OVL_XCHECK_EN
//   When defined:
//     - X/Z on test_expr at an enabled edge raises fire[2].
//     - That edge performs no step or hold check and leaves the state untouched.
//     - X/Z on enable counts as enable=0.
//   When undefined, fire[2] is tied low and no X/Z logic exists.

module ovl_step_delta #(
  parameter int WIDTH     = 4,
  parameter int VALUE     = 1,
  parameter int MODE      = 0,
  parameter int ALLOW_WRAP = 1,
  parameter int MAX_HOLD  = 0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     test_expr,
  output logic [2:0]           fire,
  output logic [CNT_WIDTH-1:0] fire_count,
  output logic                 armed
);

  // The hold counter must reach MAX_HOLD; one spare bit keeps it wide enough
  // in every case, including MAX_HOLD=0 where it only saturates.
  localparam int HOLD_W = $clog2(MAX_HOLD + 1) + 1;
  localparam logic [WIDTH-1:0]  STEP     = WIDTH'(VALUE);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  typedef enum logic {DISARMED = 1'b0, ARMED = 1'b1} state_t;

  state_t                 state_reg, state_next;
  logic [WIDTH-1:0]       prev_reg, prev_next;
  logic [HOLD_W-1:0]      hold_reg, hold_next;
  logic [2:0]             fire_reg, fire_next;
  logic [CNT_WIDTH-1:0]   count_reg, count_next;

  logic                   en_eff;
  logic [WIDTH-1:0]       dn;
  logic [WIDTH-1:0]       up;
  logic                   dec_ok;
  logic                   inc_ok;
  logic                   legal;
  logic                   changed;

`ifdef IVL_UVM_OVL_XCHECK_EN
  logic xz;
  // Only a definite 1 on enable counts as enabled.
  assign en_eff = (enable === 1'b1);
  assign xz     = $isunknown(test_expr);
`else
  assign en_eff = enable;
`endif

  // Modular step distances in both directions.
  assign dn      = prev_reg - test_expr;
  assign up      = test_expr - prev_reg;
  assign changed = (test_expr != prev_reg);

  // With wrap banned, a step whose distance only matches modularly is illegal:
  // a "decrement" that went up, or an "increment" that went down.
  assign dec_ok = (dn == STEP) && ((ALLOW_WRAP != 0) || !(test_expr > prev_reg));
  assign inc_ok = (up == STEP) && ((ALLOW_WRAP != 0) || !(test_expr < prev_reg));

  always_comb begin
    case (MODE)
      0:       legal = dec_ok;
      1:       legal = inc_ok;
      default: legal = dec_ok | inc_ok;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    prev_next  = prev_reg;
    hold_next  = hold_reg;
    fire_next  = 3'b000;

    if (!en_eff) begin
      state_next = DISARMED;
      hold_next  = '0;
    end
`ifdef IVL_UVM_OVL_XCHECK_EN
    else if (xz) begin
      // Report only; the reference sample and hold progress are kept.
      fire_next = 3'b100;
    end
`endif
    else if (state_reg == DISARMED) begin
      // Capturing edge: take the reference, no check.
      prev_next  = test_expr;
      state_next = ARMED;
    end else begin
      prev_next = test_expr;
      if (changed) begin
        hold_next = '0;
        if (!legal) begin
          fire_next[0] = 1'b1;
        end
      end else if ((MAX_HOLD != 0) && (hold_reg == HOLD_LIM)) begin
        // This edge is hold number MAX_HOLD+1: time out and restart.
        hold_next    = '0;
        fire_next[1] = 1'b1;
      end else if (hold_reg != '1) begin
        hold_next = hold_reg + 1'b1;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    if ((fire_next != 3'b000) && (count_reg != '1)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= DISARMED;
      prev_reg  <= '0;
      hold_reg  <= '0;
      fire_reg  <= 3'b000;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      prev_reg  <= prev_next;
      hold_reg  <= hold_next;
      fire_reg  <= fire_next;
      count_reg <= count_next;
    end
  end

  assign fire       = fire_reg;
  assign fire_count = count_reg;
  assign armed      = (state_reg == ARMED);

endmodule

// File: tb/tb_ovl_step_delta.sv
module tb_ovl_step_delta;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] test_expr = 4'd0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Default configuration.
  logic [2:0] def_fire;
  logic [7:0] def_count;
  logic       def_armed;

  // ALLOW_WRAP = 0.
  logic [2:0] nw_fire;
  logic [7:0] nw_count;
  logic       nw_armed;

  // MODE = 2, VALUE = 2.
  logic [2:0] m2_fire;
  logic [7:0] m2_count;
  logic       m2_armed;

  // MAX_HOLD = 3.
  logic [2:0] hd_fire;
  logic [7:0] hd_count;
  logic       hd_armed;

  // CNT_WIDTH = 2.
  logic [2:0] st_fire;
  logic [1:0] st_count;
  logic       st_armed;

  ovl_step_delta u_def (
    .clock(clock), .reset(reset), .enable(enable), .test_expr(test_expr),
    .fire(def_fire), .fire_count(def_count), .armed(def_armed));

  ovl_step_delta #(.ALLOW_WRAP(0)) u_nw (
    .clock(clock), .reset(reset), .enable(enable), .test_expr(test_expr),
    .fire(nw_fire), .fire_count(nw_count), .armed(nw_armed));

  ovl_step_delta #(.MODE(2), .VALUE(2)) u_m2 (
    .clock(clock), .reset(reset), .enable(enable), .test_expr(test_expr),
    .fire(m2_fire), .fire_count(m2_count), .armed(m2_armed));

  ovl_step_delta #(.MAX_HOLD(3)) u_hd (
    .clock(clock), .reset(reset), .enable(enable), .test_expr(test_expr),
    .fire(hd_fire), .fire_count(hd_count), .armed(hd_armed));

  ovl_step_delta #(.CNT_WIDTH(2)) u_st (
    .clock(clock), .reset(reset), .enable(enable), .test_expr(test_expr),
    .fire(st_fire), .fire_count(st_count), .armed(st_armed));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a value 1 time unit after an edge, then sample 1 unit after the next edge.
  task automatic step(input logic [3:0] v);
    test_expr = v;
    @(posedge clock);
    #1;
  endtask

  // Hold reset across one edge; inputs are released 1 unit after that edge.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state.
    @(posedge clock);
    #1;
    check("rst_fire",  32'(def_fire),  32'h0);
    check("rst_count", 32'(def_count), 32'h0);
    check("rst_armed", 32'(def_armed), 32'h0);
    reset  = 1'b0;
    enable = 1'b1;

    // Legal decrement run 5..0.
    step(4'd5);
    check("dec_arm_armed", 32'(def_armed), 32'h1);
    check("dec_arm_fire",  32'(def_fire),  32'h0);
    for (int v = 4; v >= 0; v--) begin
      step(4'(v));
      check("dec_run_fire", 32'(def_fire), 32'h0);
    end
    check("dec_run_count", 32'(def_count), 32'h0);

    // 5 -> 3 is an illegal step; 3 -> 2 is legal.
    do_reset();
    step(4'd5);
    step(4'd3);
    check("bad_step_fire",  32'(def_fire),  32'h1);
    check("bad_step_count", 32'(def_count), 32'h1);
    step(4'd2);
    check("after_bad_fire",  32'(def_fire),  32'h0);
    check("after_bad_count", 32'(def_count), 32'h1);

    // 0 -> 15: legal via wrap, illegal with wrap banned.
    do_reset();
    step(4'd0);
    step(4'd15);
    check("wrap_ok_fire",  32'(def_fire), 32'h0);
    check("nowrap_fire",   32'(nw_fire),  32'h1);
    check("nowrap_count",  32'(nw_count), 32'h1);

    // MODE 2, VALUE 2: 6 -> 8 -> 6 is legal; 6 -> 7 is not.
    do_reset();
    step(4'd6);
    step(4'd8);
    check("m2_up_fire", 32'(m2_fire), 32'h0);
    step(4'd6);
    check("m2_dn_fire", 32'(m2_fire), 32'h0);
    step(4'd7);
    check("m2_bad_fire", 32'(m2_fire), 32'h1);

    // MAX_HOLD 3: timeout on the 4th unchanged edge, repeatedly.
    do_reset();
    step(4'd6);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        step(4'd6);
        check("hold_wait_fire", 32'(hd_fire), 32'h0);
      end
      step(4'd6);
      check("hold_to_fire",  32'(hd_fire),  32'h2);
      check("hold_to_count", 32'(hd_count), 32'(r + 1));
    end

    // A change clears the hold count: 2 holds, then 5, then a full 4 holds.
    step(4'd6);
    step(4'd6);
    step(4'd5);
    check("hold_chg_fire", 32'(hd_fire), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(4'd5);
      check("hold_clr_fire", 32'(hd_fire), 32'h0);
    end
    step(4'd5);
    check("hold_clr_to_fire", 32'(hd_fire), 32'h2);

    // Disable for 3 edges, then re-arm on the new value.
    do_reset();
    step(4'd5);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(4'd9);
      check("dis_armed", 32'(def_armed), 32'h0);
      check("dis_fire",  32'(def_fire),  32'h0);
    end
    enable = 1'b1;
    step(4'd9);
    check("rearm_armed", 32'(def_armed), 32'h1);
    check("rearm_fire",  32'(def_fire),  32'h0);
    step(4'd8);
    check("rearm_step_fire", 32'(def_fire), 32'h0);

    // Mid-cycle reset clears outputs at once; next edge only re-arms.
    step(4'd3);
    check("pre_rst_fire",  32'(def_fire),  32'h1);
    check("pre_rst_count", 32'(def_count), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_fire",  32'(def_fire),  32'h0);
    check("async_rst_count", 32'(def_count), 32'h0);
    check("async_rst_armed", 32'(def_armed), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(4'd4);
    check("post_rst_armed", 32'(def_armed), 32'h1);
    check("post_rst_fire",  32'(def_fire),  32'h0);
    step(4'd3);
    check("post_rst_step_fire", 32'(def_fire), 32'h0);

    // Saturation with CNT_WIDTH 2.
    do_reset();
    step(4'd5);
    step(4'd1);
    check("sat1_fire",  32'(st_fire),  32'h1);
    check("sat1_count", 32'(st_count), 32'h1);
    step(4'd5);
    check("sat2_count", 32'(st_count), 32'h2);
    step(4'd1);
    check("sat3_count", 32'(st_count), 32'h3);
    step(4'd5);
    check("sat4_count", 32'(st_count), 32'h3);
    step(4'd1);
    check("sat5_fire",  32'(st_fire),  32'h1);
    check("sat5_count", 32'(st_count), 32'h3);

`ifdef IVL_UVM_OVL_XCHECK_EN
    // X/Z sample fires bit 2 and leaves the reference at 1.
    step(4'bx1x0);
    check("xz_fire", 32'(def_fire), 32'h4);
    step(4'd0);
    check("xz_prev_kept_fire", 32'(def_fire), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
